// File: rtl/fu_x_pkg.sv
// Shared encodings for the repeat function unit: op codes, size codes, FSM states
// and the operand-width lookup.
package fu_x_pkg;

  localparam int DATA_W_DEF  = 20;
  localparam int MAX_RPT_DEF = 16;

  typedef enum logic [3:0] {
    OP_MOV  = 4'd0,  OP_ADD  = 4'd1,  OP_ADDC = 4'd2,  OP_SUB  = 4'd3,
    OP_SUBC = 4'd4,  OP_DADD = 4'd5,  OP_AND  = 4'd6,  OP_XOR  = 4'd7,
    OP_BIS  = 4'd8,  OP_BIC  = 4'd9,  OP_RRC  = 4'd10, OP_RRA  = 4'd11,
    OP_RLA  = 4'd12, OP_RLC  = 4'd13
  } op_t;

  // Size codes are the {AL,BW} bits of the extended instruction word.
  localparam logic [1:0] SZ_BYTE = 2'b11;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ADDR = 2'b01;
  localparam logic [1:0] SZ_RSV  = 2'b00;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic logic [4:0] fu_width(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 5'd8;
      SZ_WORD: return 5'd16;
      default: return 5'd20;
    endcase
  endfunction

  function automatic logic op_defined(input logic [3:0] op);
    return op <= OP_RLC;
  endfunction

endpackage

// File: rtl/fu_repeat_unit_if.sv
// Issue/result bundle between the decoder (master) and the repeat function unit (slave).
interface fu_repeat_unit_if #(
  parameter int DATA_W  = 20,
  parameter int MAX_RPT = 16
);
  localparam int CNT_W = $clog2(MAX_RPT);

  // Handshake: start is taken only in a cycle where busy==0; the request is captured on
  // that rising edge. done pulses for exactly one cycle when result/flags/err are valid,
  // and busy is already low in that cycle so a new start there is accepted back-to-back.
  logic              start;
  logic [3:0]        op;
  logic [1:0]        size;
  logic [CNT_W-1:0]  rpt_m1;
  logic              zc;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] dst;
  logic              Zin, Vin, Nin, Cin;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;
  logic              Zout, Vout, Nout, Cout;

  modport master (
    output start, op, size, rpt_m1, zc, src, dst, Zin, Vin, Nin, Cin,
    input  busy, done, err, result, Zout, Vout, Nout, Cout
  );

  modport slave (
    input  start, op, size, rpt_m1, zc, src, dst, Zin, Vin, Nin, Cin,
    output busy, done, err, result, Zout, Vout, Nout, Cout
  );
endinterface

// File: rtl/fu_x_step.sv
// One combinational iteration of the repeat unit: applies op at width 8/16/20 to the
// source operand and the running accumulator, producing result and status bits.
module fu_x_step
  import fu_x_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        i_op,
  input  logic [1:0]        i_size,
  input  logic [DATA_W-1:0] i_src,
  input  logic [DATA_W-1:0] i_dst,
  input  logic              i_cin,
  output logic [DATA_W-1:0] o_res,
  output logic              o_z,
  output logic              o_v,
  output logic              o_n,
  output logic              o_c,
  output logic              o_keep
);

  logic [4:0]        w_w;
  logic [DATA_W-1:0] w_msk, w_top, w_a, w_s, w_b;
  logic [DATA_W:0]   w_sum;
  logic              w_am, w_sm, w_bm, w_ci, w_dc;
  logic [4:0]        w_ds;

  always_comb begin
    w_w    = fu_width(i_size);
    w_msk  = ~({DATA_W{1'b1}} << w_w);
    w_top  = {{(DATA_W-1){1'b0}}, 1'b1} << (w_w - 5'd1);
    w_a    = i_dst & w_msk;
    w_s    = i_src & w_msk;
    w_am   = |(w_a & w_top);
    w_sm   = |(w_s & w_top);
    w_b    = '0;
    w_ci   = 1'b0;
    w_dc   = i_cin;
    w_ds   = '0;
    o_res  = '0;
    o_c    = 1'b0;
    o_v    = 1'b0;
    o_keep = 1'b0;

    // Shared adder: subtraction is dst + ~src + carry, rotates-left are dst + dst + carry.
    case (i_op)
      OP_ADD:  w_b = w_s;
      OP_ADDC: begin w_b = w_s;          w_ci = i_cin; end
      OP_SUB:  begin w_b = ~w_s & w_msk; w_ci = 1'b1;  end
      OP_SUBC: begin w_b = ~w_s & w_msk; w_ci = i_cin; end
      OP_RLA:  w_b = w_a;
      OP_RLC:  begin w_b = w_a;          w_ci = i_cin; end
      default: ;
    endcase
    w_sum = {1'b0, w_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_ci};
    w_bm  = |(w_b & w_top);

    case (i_op)
      OP_MOV: begin o_res = w_s; o_keep = 1'b1; end
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_RLA, OP_RLC: begin
        o_res = w_sum[DATA_W-1:0] & w_msk;
        o_c   = |(w_sum >> w_w);
        o_v   = (w_am == w_bm) && ((|(o_res & w_top)) != w_am);
      end
      OP_DADD: begin
        for (int i = 0; i < DATA_W / 4; i++) begin
          if (i < int'(w_w >> 2)) begin
            w_ds = {1'b0, w_a[4*i +: 4]} + {1'b0, w_s[4*i +: 4]} + {4'b0000, w_dc};
            if (w_ds > 5'd9) begin
              o_res[4*i +: 4] = w_ds[3:0] + 4'd6;
              w_dc            = 1'b1;
            end else begin
              o_res[4*i +: 4] = w_ds[3:0];
              w_dc            = 1'b0;
            end
          end
        end
        o_c = w_dc;
      end
      OP_AND: begin o_res = w_a & w_s; o_c = |o_res; end
      OP_XOR: begin o_res = w_a ^ w_s; o_c = |o_res; o_v = w_sm & w_am; end
      OP_BIS: begin o_res = w_a | w_s;  o_keep = 1'b1; end
      OP_BIC: begin o_res = w_a & ~w_s; o_keep = 1'b1; end
      OP_RRC: begin o_res = (w_a >> 1) | (i_cin ? w_top : '0); o_c = w_a[0]; end
      OP_RRA: begin o_res = (w_a >> 1) | (w_am ? w_top : '0);  o_c = w_a[0]; end
      default: ;
    endcase

    o_z = (o_res == '0);
    o_n = |(o_res & w_top);
  end

endmodule

// File: rtl/fu_repeat_unit.sv
// Multi-cycle MSP430X function unit: repeats one ALU op 1..MAX_RPT times, one iteration
// per clock, chaining the accumulator and carry between iterations.
module fu_repeat_unit
  import fu_x_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_RPT = MAX_RPT_DEF
) (
  input  logic             MCLK,
  input  logic             RST_n,
  fu_repeat_unit_if.slave  bus,
  output state_t           o_dbg_state
);

  localparam int CNT_W = $clog2(MAX_RPT);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_op;
  logic [1:0]        r_size;
  logic              r_zc, r_c, r_err, r_done;
  logic [DATA_W-1:0] r_src, r_acc, r_result;
  logic              r_zin, r_vin, r_nin, r_cin;
  logic              r_zout, r_vout, r_nout, r_cout;
  logic              w_accept, w_last, w_bad;
  logic [DATA_W-1:0] w_res;
  logic              w_z, w_v, w_n, w_c, w_keep;

  assign w_bad = !op_defined(bus.op) || (bus.size == SZ_RSV);

  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_accept    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: if (r_cnt == '0) begin
        w_last      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  fu_x_step #(.DATA_W(DATA_W)) u_step (
    .i_op   (r_op),
    .i_size (r_size),
    .i_src  (r_src),
    .i_dst  (r_acc),
    .i_cin  (r_c & ~r_zc),
    .o_res  (w_res),
    .o_z    (w_z),
    .o_v    (w_v),
    .o_n    (w_n),
    .o_c    (w_c),
    .o_keep (w_keep)
  );

  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) begin
      r_cnt <= '0;  r_op <= '0;  r_size <= '0;  r_zc <= 1'b0;  r_c <= 1'b0;
      r_err <= 1'b0;  r_done <= 1'b0;  r_src <= '0;  r_acc <= '0;  r_result <= '0;
      r_zin <= 1'b0;  r_vin <= 1'b0;  r_nin <= 1'b0;  r_cin <= 1'b0;
      r_zout <= 1'b0; r_vout <= 1'b0; r_nout <= 1'b0; r_cout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op   <= bus.op;   r_size <= bus.size;  r_zc  <= bus.zc;
        r_src  <= bus.src;  r_acc  <= bus.dst;   r_c   <= bus.Cin;
        r_zin  <= bus.Zin;  r_vin  <= bus.Vin;   r_nin <= bus.Nin;  r_cin <= bus.Cin;
        r_err  <= w_bad;
        // A rejected request still spends one cycle so done/err arrive on a fixed schedule.
        r_cnt  <= w_bad ? '0 : bus.rpt_m1;
      end else if (r_state == S_RUN) begin
        r_acc <= w_res;
        if (!w_keep) r_c <= w_c;
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_done <= 1'b1;
          if (r_err) begin
            r_result <= '0;
            {r_zout, r_vout, r_nout, r_cout} <= {r_zin, r_vin, 1'b1, r_cin};
          end else if (w_keep) begin
            r_result <= w_res;
            {r_zout, r_vout, r_nout, r_cout} <= {r_zin, r_vin, r_nin, r_cin};
          end else begin
            r_result <= w_res;
            {r_zout, r_vout, r_nout, r_cout} <= {w_z, w_v, w_n, w_c};
          end
        end
      end
    end
  end

  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.result  = r_result;
  assign bus.Zout    = r_zout;
  assign bus.Vout    = r_vout;
  assign bus.Nout    = r_nout;
  assign bus.Cout    = r_cout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fu_repeat_unit.sv
// Scoreboard bench for fu_repeat_unit: directed cases plus random requests checked
// against an arithmetic reference model.
module tb_fu_repeat_unit;
  import fu_x_pkg::*;

  localparam int DATA_W = 20;
  localparam int PW     = DATA_W + 5;

  logic   MCLK = 1'b0;
  logic   RST_n;
  state_t dbg_state;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  logic [PW-1:0] exp_q[$];
  int            lat_q[$];

  fu_repeat_unit_if #(.DATA_W(DATA_W)) bus ();

  fu_repeat_unit #(.DATA_W(DATA_W)) dut (
    .MCLK        (MCLK),
    .RST_n       (RST_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 MCLK = ~MCLK;
  always @(posedge MCLK) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic int sg(input int x, input int w);
    return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
  endfunction

  function automatic int bcd2int(input int x);
    int v = 0, mul = 1;
    for (int i = 0; i < 5; i++) begin
      v += ((x >> (4 * i)) & 15) * mul;
      mul *= 10;
    end
    return v;
  endfunction

  function automatic int int2bcd(input int x);
    int r = 0, v = x;
    for (int i = 0; i < 5; i++) begin
      r |= (v % 10) << (4 * i);
      v /= 10;
    end
    return r;
  endfunction

  // Reference model: {err, Z, V, N, C, result}.
  function automatic logic [PW-1:0] model(input logic [3:0] op, input logic [1:0] size,
                                          input logic [3:0] rpt, input logic zc,
                                          input logic [DATA_W-1:0] src, input logic [DATA_W-1:0] dst,
                                          input logic [3:0] fl);
    int w, m, half, acc, s, r, u, se, k, p;
    logic zi, vi, ni, ci, c, z, v, n, cf, vf, upd, cin;
    {zi, vi, ni, ci} = fl;
    if (size == 2'b00 || op > 4'd13) return {1'b1, zi, vi, 1'b1, ci, {DATA_W{1'b0}}};
    w    = (size == 2'b11) ? 8 : (size == 2'b10) ? 16 : 20;
    m    = (1 << w) - 1;
    half = 1 << (w - 1);
    acc  = int'(dst) & m;
    s    = int'(src) & m;
    c = ci; z = zi; v = vi; n = ni;
    for (int it = 0; it <= int'(rpt); it++) begin
      cin = zc ? 1'b0 : c;
      upd = 1'b1; cf = 1'b0; vf = 1'b0; r = 0;
      case (op)
        4'd0: begin r = s; upd = 1'b0; end
        4'd1, 4'd2: begin
          k  = (op == 4'd2) ? int'(cin) : 0;
          u  = acc + s + k;
          se = sg(acc, w) + sg(s, w) + k;
          r = u & m; cf = (u > m); vf = (se >= half) || (se < -half);
        end
        4'd3, 4'd4: begin
          k  = (op == 4'd3) ? 0 : 1 - int'(cin);
          u  = acc - s - k;
          se = sg(acc, w) - sg(s, w) - k;
          r = u & m; cf = (u >= 0); vf = (se >= half) || (se < -half);
        end
        4'd12, 4'd13: begin
          k  = (op == 4'd13) ? int'(cin) : 0;
          u  = 2 * acc + k;
          se = 2 * sg(acc, w) + k;
          r = u & m; cf = (u > m); vf = (se >= half) || (se < -half);
        end
        4'd5: begin
          p = 1;
          for (int d = 0; d < w / 4; d++) p *= 10;
          u  = bcd2int(acc) + bcd2int(s) + int'(cin);
          cf = (u >= p);
          r  = int2bcd(u % p);
        end
        4'd6: begin r = acc & s; cf = (r != 0); end
        4'd7: begin r = acc ^ s; cf = (r != 0); vf = (acc >= half) && (s >= half); end
        4'd8: begin r = acc | s; upd = 1'b0; end
        4'd9: begin r = acc & ~s; upd = 1'b0; end
        4'd10: begin r = acc / 2 + (cin ? half : 0); cf = (acc % 2 == 1); end
        4'd11: begin r = acc / 2 + ((acc >= half) ? half : 0); cf = (acc % 2 == 1); end
        default: ;
      endcase
      acc = r;
      if (upd) begin
        c = cf; v = vf; z = (r == 0); n = (r >= half);
      end
    end
    return {1'b0, z, v, n, c, DATA_W'(acc)};
  endfunction

  function automatic logic [DATA_W-1:0] rand_bcd();
    logic [DATA_W-1:0] r = '0;
    for (int i = 0; i < DATA_W / 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic scramble();
    bus.op     = 4'($urandom);
    bus.size   = 2'($urandom);
    bus.rpt_m1 = 4'($urandom);
    bus.zc     = 1'($urandom);
    bus.src    = DATA_W'($urandom);
    bus.dst    = DATA_W'($urandom);
    {bus.Zin, bus.Vin, bus.Nin, bus.Cin} = 4'($urandom);
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] size, input logic [3:0] rpt,
                       input logic zc, input logic [DATA_W-1:0] src,
                       input logic [DATA_W-1:0] dst, input logic [3:0] fl);
    int t = 0;
    int n;
    while (bus.busy === 1'b1 && t < 40) begin
      @(negedge MCLK);
      t++;
    end
    if (bus.busy !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_wait: busy=%b after %0d cycles, expected 0", bus.busy, t);
      return;
    end
    bus.start = 1'b1; bus.op = op; bus.size = size; bus.rpt_m1 = rpt; bus.zc = zc;
    bus.src = src; bus.dst = dst; {bus.Zin, bus.Vin, bus.Nin, bus.Cin} = fl;
    n = (size == 2'b00 || op > 4'd13) ? 1 : int'(rpt) + 1;
    exp_q.push_back(model(op, size, rpt, zc, src, dst, fl));
    lat_q.push_back(cyc + 1 + n);
    @(negedge MCLK);
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    // While busy, a stray start and changing operands must be ignored.
    scramble();
    bus.start = (n >= 3);
    if (n >= 3) begin
      @(negedge MCLK);
      scramble();
      bus.start = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge MCLK);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding after %0d cycles, expected 0", exp_q.size(), t);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge MCLK) begin
    if (RST_n === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending result", cyc);
      end else begin
        chk("result_flags",
            64'({bus.err, bus.Zout, bus.Vout, bus.Nout, bus.Cout, bus.result}),
            64'(exp_q.pop_front()));
        chk("done_cycle", 64'(cyc), 64'(lat_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]        r_op;
    logic [1:0]        r_size;
    logic [DATA_W-1:0] r_src, r_dst;

    RST_n = 1'b0;
    bus.start = 1'b0;
    scramble();
    repeat (3) @(negedge MCLK);
    RST_n = 1'b1;
    @(negedge MCLK);
    chk("rst_busy",   64'(bus.busy),   64'd0);
    chk("rst_done",   64'(bus.done),   64'd0);
    chk("rst_err",    64'(bus.err),    64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_flags",  64'({bus.Zout, bus.Vout, bus.Nout, bus.Cout}), 64'd0);
    chk("rst_state",  64'(dbg_state),  64'(S_IDLE));

    // Directed cases, issued back-to-back.
    issue(OP_RRC,  SZ_WORD, 4'd3,  1'b0, 20'h00000, 20'h00010, 4'b0001);
    issue(OP_RRC,  SZ_WORD, 4'd15, 1'b1, 20'h00000, 20'h0FFFF, 4'b0000);
    issue(OP_ADD,  SZ_ADDR, 4'd0,  1'b0, 20'h00001, 20'hFFFFF, 4'b0000);
    issue(OP_ADDC, SZ_BYTE, 4'd2,  1'b0, 20'h00080, 20'h00080, 4'b0000);
    issue(OP_DADD, SZ_WORD, 4'd0,  1'b0, 20'h00001, 20'h00099, 4'b0000);
    issue(OP_ADD,  SZ_RSV,  4'd3,  1'b0, 20'h12345, 20'h54321, 4'b1011);
    issue(4'd14,   SZ_WORD, 4'd5,  1'b0, 20'h00001, 20'h00002, 4'b0100);
    issue(OP_MOV,  SZ_BYTE, 4'd4,  1'b0, 20'h001AB, 20'h00000, 4'b1101);
    issue(OP_SUB,  SZ_WORD, 4'd1,  1'b0, 20'h00001, 20'h08000, 4'b0000);
    issue(OP_RRC,  SZ_WORD, 4'd0,  1'b0, 20'h00000, 20'h02002, 4'b0000);
    drain();

    // Asynchronous reset in the middle of a 16-iteration run.
    issue(OP_ADD, SZ_WORD, 4'd15, 1'b0, 20'h00003, 20'h00100, 4'b0000);
    repeat (5) @(posedge MCLK);
    #3 RST_n = 1'b0;
    #1;
    chk("midrst_busy",   64'(bus.busy),   64'd0);
    chk("midrst_done",   64'(bus.done),   64'd0);
    chk("midrst_result", 64'(bus.result), 64'd0);
    chk("midrst_state",  64'(dbg_state),  64'(S_IDLE));
    exp_q.delete();
    lat_q.delete();
    @(negedge MCLK);
    RST_n = 1'b1;
    issue(OP_XOR, SZ_WORD, 4'd1, 1'b0, 20'h08001, 20'h0F00F, 4'b0000);

    // Random requests, mostly legal, some reserved sizes and undefined ops.
    for (int i = 0; i < 150; i++) begin
      r_op   = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom_range(0, 13));
      r_size = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      r_src  = DATA_W'($urandom);
      r_dst  = DATA_W'($urandom);
      if (r_op == OP_DADD) begin
        r_src = rand_bcd();
        r_dst = rand_bcd();
      end
      issue(r_op, r_size, 4'($urandom_range(0, 15)), 1'($urandom), r_src, r_dst, 4'($urandom));
    end
    drain();
    @(negedge MCLK);
    chk("idle_at_end", 64'(bus.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
